// File: rtl/nf2_reg_cmd_bridge_if.sv
// +--------------------------------------------------------------------------+
// | nf2_reg_cmd_bridge_if : host Avalon-MM side plus register-group side.     |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

interface nf2_reg_cmd_bridge_if #(
  parameter int ADDR_WIDTH = 27,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] av_address;
  logic                  av_read;
  logic                  av_write;
  logic [DATA_WIDTH-1:0] av_writedata;
  logic                  av_waitrequest;
  logic [DATA_WIDTH-1:0] av_readdata;
  logic                  av_readdatavalid;
  logic                  fifo_empty;
  logic                  fifo_rd_en;
  logic                  bus_rd_wr_L;
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic [DATA_WIDTH-1:0] bus_wr_data;
  logic [DATA_WIDTH-1:0] bus_rd_data;
  logic                  bus_rd_vld;

  modport slave (
    input  av_address, av_read, av_write, av_writedata,
    input  fifo_rd_en, bus_rd_data, bus_rd_vld,
    output av_waitrequest, av_readdata, av_readdatavalid,
    output fifo_empty, bus_rd_wr_L, bus_addr, bus_wr_data
  );

  modport master (
    output av_address, av_read, av_write, av_writedata,
    output fifo_rd_en, bus_rd_data, bus_rd_vld,
    input  av_waitrequest, av_readdata, av_readdatavalid,
    input  fifo_empty, bus_rd_wr_L, bus_addr, bus_wr_data
  );
endinterface

`default_nettype wire

// File: rtl/nf2_reg_cmd_bridge.sv
// +--------------------------------------------------------------------------+
// | nf2_reg_cmd_bridge : Avalon-MM host accesses -> command FIFO -> NF2 regs. |
// | Optional counters: NF2_REG_CMD_BRIDGE_STATS_EN.  Revision 1.0            |
// +--------------------------------------------------------------------------+
`default_nettype none

module nf2_reg_cmd_bridge #(
  parameter int ADDR_WIDTH         = 27,
  parameter int DATA_WIDTH         = 32,
  parameter int FIFO_DEPTH_LOG2    = 4,
  parameter int MAX_RD_OUTSTANDING = 8
) (
  input  wire logic            clk,
  input  wire logic            reset_n,
  nf2_reg_cmd_bridge_if.slave  ifc,
  output logic                 rsp_err,
  output logic [31:0]          stat_wr_cnt,
  output logic [31:0]          stat_rd_cnt
);

  localparam int DEPTH   = 1 << FIFO_DEPTH_LOG2;
  localparam int ENTRY_W = 1 + ADDR_WIDTH + DATA_WIDTH;
  localparam int OUT_W   = $clog2(MAX_RD_OUTSTANDING + 1);
  localparam logic [OUT_W-1:0]         OUT_MAX  = OUT_W'(MAX_RD_OUTSTANDING);
  localparam logic [FIFO_DEPTH_LOG2:0] CNT_FULL = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);

  logic [ENTRY_W-1:0]         mem_q [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_DEPTH_LOG2:0]   cnt_q, cnt_d;
  logic [OUT_W-1:0]           outst_q, outst_d;
  logic                       rd_wr_l_q, rd_wr_l_d;
  logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
  logic [DATA_WIDTH-1:0]      wdata_q, wdata_d;
  logic                       rdv_q, rdv_d;
  logic [DATA_WIDTH-1:0]      rdata_q, rdata_d;
  logic                       err_q, err_d;

  logic                  fifo_full, fifo_empty, waitreq;
  logic                  acc, acc_rd, pop;
  logic                  rsp_ok, rsp_stray;
  logic [DATA_WIDTH-1:0] push_wdata;
  logic [ENTRY_W-1:0]    push_entry, head_entry;

  always_comb begin
    fifo_full  = (cnt_q == CNT_FULL);
    fifo_empty = (cnt_q == '0);
    waitreq    = fifo_full | (ifc.av_read & ~ifc.av_write & (outst_q == OUT_MAX));
    acc        = (ifc.av_read | ifc.av_write) & ~waitreq;
    // A simultaneous read+write is a write; the read half is dropped.
    acc_rd     = acc & ~ifc.av_write;
    pop        = ifc.fifo_rd_en & ~fifo_empty;
    push_wdata = ifc.av_write ? ifc.av_writedata : '0;
    push_entry = {~ifc.av_write, ifc.av_address, push_wdata};
    head_entry = mem_q[rd_ptr_q];
    // A strobe with nothing outstanding is only legal if a read is accepted on the same edge.
    rsp_stray  = ifc.bus_rd_vld & (outst_q == '0) & ~acc_rd;
    rsp_ok     = ifc.bus_rd_vld & ~rsp_stray;
  end

  always_comb begin
    wr_ptr_d  = acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d     = cnt_q;
    outst_d   = outst_q;
    rd_wr_l_d = rd_wr_l_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    rdv_d     = rsp_ok;
    err_d     = err_q | rsp_stray;

    case ({acc, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

    case ({acc_rd, rsp_ok})
      2'b10:   outst_d = outst_q + 1'b1;
      2'b01:   outst_d = outst_q - 1'b1;
      default: outst_d = outst_q;
    endcase

    if (pop) begin
      {rd_wr_l_d, addr_d, wdata_d} = head_entry;
    end
    if (rsp_ok) begin
      rdata_d = ifc.bus_rd_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      outst_q   <= '0;
      rd_wr_l_q <= 1'b1;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdv_q     <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      outst_q   <= outst_d;
      rd_wr_l_q <= rd_wr_l_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdv_q     <= rdv_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  // Storage needs no reset: occupancy is governed solely by the pointers and count.
  always_ff @(posedge clk) begin
    if (acc) begin
      mem_q[wr_ptr_q] <= push_entry;
    end
  end

  assign ifc.av_waitrequest   = waitreq;
  assign ifc.av_readdata      = rdata_q;
  assign ifc.av_readdatavalid = rdv_q;
  assign ifc.fifo_empty       = fifo_empty;
  assign ifc.bus_rd_wr_L      = rd_wr_l_q;
  assign ifc.bus_addr         = addr_q;
  assign ifc.bus_wr_data      = wdata_q;
  assign rsp_err              = err_q;

`ifdef NF2_REG_CMD_BRIDGE_STATS_EN
  logic [31:0] stat_wr_q, stat_wr_d, stat_rd_q, stat_rd_d;

  always_comb begin
    stat_wr_d = (acc & ifc.av_write) ? stat_wr_q + 32'd1 : stat_wr_q;
    stat_rd_d = acc_rd ? stat_rd_q + 32'd1 : stat_rd_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_wr_q <= '0;
      stat_rd_q <= '0;
    end else begin
      stat_wr_q <= stat_wr_d;
      stat_rd_q <= stat_rd_d;
    end
  end

  assign stat_wr_cnt = stat_wr_q;
  assign stat_rd_cnt = stat_rd_q;
`else
  assign stat_wr_cnt = '0;
  assign stat_rd_cnt = '0;
`endif

endmodule

`default_nettype wire
